// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C master state encoding and bus constants
package i2c_pkg;
  localparam logic       I2C_RD         = 1'b1;
  localparam int         I2C_HALF_STEPS = 41;
  localparam logic [6:0] I2C_ADDR       = 7'h42;
  typedef enum logic [3:0] {
    IDLE, ST_A, ST_B, ADDR_L, ADDR_H, AACK_L, AACK_H,
    DATA_L, DATA_H, MACK_L, MACK_H, SP_A, SP_B, SP_C, DONE
  } i2c_mstate_t;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: one-cycle strobe every HALF_PERIOD clocks while enabled
module i2c_tick_gen #(
  parameter int HALF_PERIOD = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(HALF_PERIOD);
  localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == LAST;
  always_comb begin
    cnt_d = !en || tick ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/i2c_read_master.sv
// i2c_read_master: single-byte I2C read (START, addr+R, ACK, 8 data bits, ACK/NACK, STOP)
module i2c_read_master
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_ADDR,
  parameter int         HALF_PERIOD = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_nack,
  output logic       cmd_ready,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_addr_nack,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i,
  output logic       busy
);
  i2c_mstate_t state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] addr_sr_q, addr_sr_d, data_sr_q, data_sr_d, rsp_data_q, rsp_data_d;
  logic nack_q, nack_d, anack_q, anack_d, scl_q, scl_d, sda_q, sda_d;
  logic rsp_valid_q, rsp_valid_d, rsp_nack_q, rsp_nack_d;
  logic tick;
  i2c_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != IDLE),
    .tick (tick)
  );
  assign cmd_ready     = state_q == IDLE && !rsp_valid_q;
  assign busy          = state_q != IDLE;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_addr_nack = rsp_nack_q;
  assign scl_o         = scl_q;
  assign sda_o         = sda_q;
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    nack_d      = nack_q;
    anack_d     = anack_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_nack_d  = rsp_nack_q;
    if (state_q == IDLE) begin
      if (cmd_valid && cmd_ready) begin
        state_d   = ST_A;
        bit_d     = 3'd7;
        addr_sr_d = {SLAVE_ADDR, I2C_RD};
        data_sr_d = '0;
        nack_d    = cmd_nack;
        anack_d   = 1'b0;
      end
    end else if (state_q == DONE) begin
      state_d     = IDLE;
      rsp_valid_d = 1'b1;
      rsp_data_d  = anack_q ? 8'h00 : data_sr_q;
      rsp_nack_d  = anack_q;
    end else if (tick) begin
      case (state_q)
        ST_A:    state_d = ST_B;
        ST_B:    state_d = ADDR_L;
        ADDR_L:  state_d = ADDR_H;
        ADDR_H: begin
          addr_sr_d = addr_sr_q << 1;
          bit_d     = bit_q == 3'd0 ? 3'd7 : bit_q - 3'd1;
          state_d   = bit_q == 3'd0 ? AACK_L : ADDR_L;
        end
        AACK_L:  state_d = AACK_H;
        AACK_H: begin
          anack_d = sda_i;
          state_d = sda_i ? SP_A : DATA_L;
        end
        DATA_L:  state_d = DATA_H;
        DATA_H: begin
          data_sr_d = {data_sr_q[6:0], sda_i};
          bit_d     = bit_q == 3'd0 ? 3'd7 : bit_q - 3'd1;
          state_d   = bit_q == 3'd0 ? MACK_L : DATA_L;
        end
        MACK_L:  state_d = MACK_H;
        MACK_H:  state_d = SP_A;
        SP_A:    state_d = SP_B;
        SP_B:    state_d = SP_C;
        SP_C:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    // bus levels are decoded from the next state so they change on the same edge as the state
    scl_d = !(state_d inside {ADDR_L, AACK_L, DATA_L, MACK_L, SP_A});
    sda_d = state_d inside {ST_B, SP_A, SP_B} ? 1'b0 :
            state_d inside {ADDR_L, ADDR_H}   ? addr_sr_d[7] :
            state_d inside {MACK_L, MACK_H}   ? nack_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_q       <= 3'd7;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      nack_q      <= 1'b0;
      anack_q     <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_nack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      nack_q      <= nack_d;
      anack_q     <= anack_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_nack_q  <= rsp_nack_d;
    end
  end
endmodule

// File: tb/tb_i2c_read_master.sv
// tb_i2c_read_master: behavioural slave + half-period waveform model checked every cycle
module tb_i2c_read_master;
  localparam int HP = 32;
  localparam logic [6:0] SA = 7'h42;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_nack = 0, rsp_ready = 0;
  logic cmd_ready, rsp_valid, rsp_addr_nack, scl_o, sda_o, busy, sda_i;
  logic [7:0] rsp_data;
  logic slv_sda = 1;
  assign sda_i = sda_o & slv_sda;
  i2c_read_master #(.SLAVE_ADDR(SA), .HALF_PERIOD(HP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_nack(cmd_nack),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_addr_nack(rsp_addr_nack), .scl_o(scl_o),
    .sda_o(sda_o), .sda_i(sda_i), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  // slave: answers slv_addr, returns slv_byte, reacts to bus edges
  logic [6:0] slv_addr = SA;
  logic [7:0] slv_byte = 8'h00, sb_sh = 8'h00, seen_addr = 8'h00;
  logic seen_mack = 1'b1, last_scl = 1'b1, last_sda = 1'b1;
  int sph = 0, sb_cnt = 0, stops = 0;
  always @(negedge clk) begin : slave
    logic w;
    w = sda_o & slv_sda;
    if (!rst_n) begin
      sph = 0; slv_sda = 1'b1; last_scl = 1'b1; last_sda = 1'b1;
    end else begin
      if (scl_o && last_scl && last_sda && !w) begin
        sph = 1; sb_cnt = 0; slv_sda = 1'b1;
      end else if (scl_o && last_scl && !last_sda && w) begin
        sph = 0; stops++;
      end else if (scl_o && !last_scl) begin
        if (sph == 1) begin sb_sh = {sb_sh[6:0], w}; sb_cnt++; end
        else if (sph == 3) sb_cnt++;
        else if (sph == 4) begin seen_mack = w; sph = 5; end
      end else if (!scl_o && last_scl) begin
        if (sph == 1 && sb_cnt == 8) begin
          seen_addr = sb_sh;
          if (sb_sh == {slv_addr, 1'b1}) begin slv_sda = 1'b0; sph = 2; end
          else sph = 0;
        end else if (sph == 2) begin
          sph = 3; sb_cnt = 0; slv_sda = slv_byte[7];
        end else if (sph == 3) begin
          if (sb_cnt == 8) begin slv_sda = 1'b1; sph = 4; end
          else slv_sda = slv_byte[3'(7 - sb_cnt)];
        end
      end
      last_scl = scl_o;
      last_sda = sda_o & slv_sda;
    end
  end
  // expected {scl,sda} for half-period h of a transaction
  function automatic logic [1:0] wave(input int h, input logic ack, input logic nack);
    logic [7:0] ab;
    int g;
    ab = {SA, 1'b1};
    if (h == 0) return 2'b11;
    if (h == 1) return 2'b10;
    if (h < 18) return {1'((h - 2) % 2), ab[3'(7 - (h - 2) / 2)]};
    if (h < 20) return {1'(h - 18), 1'b1};
    g = ack ? h : h + 18;
    if (g < 36) return {1'((g - 20) % 2), 1'b1};
    if (g < 38) return {1'(g - 36), nack};
    if (g == 38) return 2'b00;
    if (g == 39) return 2'b10;
    return 2'b11;
  endfunction
  logic m_busy = 0, m_rsp = 0, m_ack = 0, m_nack = 0, m_anack = 0;
  logic [7:0] m_byte = 0, m_data = 0;
  int j = 0, n = 0;
  always @(negedge clk) begin : model
    logic acc;
    logic [1:0] e;
    if (!rst_n) begin
      m_busy = 0; m_rsp = 0; m_data = 0; m_anack = 0;
      chk("rst_scl", 32'(scl_o), 1);
      chk("rst_sda", 32'(sda_o), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_addr_nack", 32'(rsp_addr_nack), 0);
    end else begin
      acc = cmd_valid && !m_busy && !m_rsp;
      if (m_rsp && rsp_ready) m_rsp = 0;
      if (m_busy) begin
        j++;
        if (j == n + 1) begin
          m_busy = 0; m_rsp = 1; m_anack = !m_ack; m_data = m_ack ? m_byte : 8'h00;
        end
      end
      if (acc) begin
        m_busy = 1; j = 0; m_ack = slv_addr == SA; m_nack = cmd_nack; m_byte = slv_byte;
        n = (m_ack ? 41 : 23) * HP;
      end
      e = (!m_busy || j >= n) ? 2'b11 : wave(j / HP, m_ack, m_nack);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && !m_rsp));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_addr_nack", 32'(rsp_addr_nack), 32'(m_anack));
      chk("scl", 32'(scl_o), 32'(e[1]));
      chk("sda", 32'(sda_o), 32'(e[0]));
    end
  end
  int acc_cyc = 0;
  task automatic start_cmd(input logic nack);
    int k;
    @(negedge clk);
    #1 cmd_valid = 1; cmd_nack = nack;
    k = 0;
    do begin @(negedge clk); k++; end while (!busy && k < 3000);
    chk("accept_timeout", 32'(busy), 1);
    acc_cyc = cyc;
    #1 cmd_valid = 0; cmd_nack = 0;
  endtask
  task automatic wait_rsp(output int lat);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 3000);
    chk("rsp_timeout", 32'(rsp_valid), 1);
    lat = cyc - acc_cyc;
  endtask
  task automatic take_rsp();
    @(negedge clk);
    #1 rsp_ready = 1;
    @(negedge clk);
    #1 rsp_ready = 0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, k;
    logic [7:0] pat [16];
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    slv_byte = 8'hA5;
    start_cmd(1'b0);
    repeat (200) @(negedge clk);
    #1 cmd_valid = 1;
    @(negedge clk);
    #1 cmd_valid = 0;
    wait_rsp(lat);
    chk("t1_latency", lat, 1313);
    chk("t1_data", 32'(rsp_data), 'hA5);
    chk("t1_addr_nack", 32'(rsp_addr_nack), 0);
    chk("t1_wire_addr", 32'(seen_addr), 'h85);
    chk("t1_mack", 32'(seen_mack), 0);
    chk("t1_stop", stops, 1);
    take_rsp();
    slv_addr = 7'h43;
    slv_byte = 8'h5A;
    start_cmd(1'b0);
    wait_rsp(lat);
    chk("nack_latency", lat, 23 * HP + 1);
    chk("nack_data", 32'(rsp_data), 0);
    chk("nack_flag", 32'(rsp_addr_nack), 1);
    chk("nack_stop", stops, 2);
    take_rsp();
    slv_addr = SA;
    slv_byte = 8'h3C;
    start_cmd(1'b1);
    wait_rsp(lat);
    chk("t3_data", 32'(rsp_data), 'h3C);
    chk("t3_mack_released", 32'(seen_mack), 1);
    slv_byte = 8'hC3;
    #1 cmd_valid = 1;
    repeat (100) @(negedge clk);
    chk("hold_data", 32'(rsp_data), 'h3C);
    chk("hold_cmd_ready", 32'(cmd_ready), 0);
    #1 rsp_ready = 1;
    @(negedge clk);
    chk("hs_rsp_valid", 32'(rsp_valid), 0);
    chk("hs_not_yet", 32'(busy), 0);
    #1 rsp_ready = 0;
    @(negedge clk);
    chk("hs_accept", 32'(busy), 1);
    acc_cyc = cyc;
    #1 cmd_valid = 0;
    wait_rsp(lat);
    chk("t4_latency", lat, 1313);
    chk("t4_data", 32'(rsp_data), 'hC3);
    take_rsp();
    slv_byte = 8'h96;
    start_cmd(1'b0);
    k = 0;
    while (cyc - acc_cyc < 27 * HP + 5 && k < 5000) begin @(negedge clk); k++; end
    chk("pre_rst_busy", 32'(busy), 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_scl", 32'(scl_o), 1);
    chk("mid_rst_sda", 32'(sda_o), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1;
    slv_byte = 8'h69;
    start_cmd(1'b0);
    wait_rsp(lat);
    chk("post_rst_data", 32'(rsp_data), 'h69);
    chk("post_rst_latency", lat, 1313);
    take_rsp();
    for (int i = 0; i < 16; i++) begin
      pat[i] = 8'($urandom);
      slv_byte = pat[i];
      start_cmd(1'($urandom));
      wait_rsp(lat);
      chk("rand_data", 32'(rsp_data), 32'(pat[i]));
      chk("rand_addr_nack", 32'(rsp_addr_nack), 0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      take_rsp();
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
